program_counter_ras: RTL and testbench

- Next-generation program counter for the MIPS32 core.
- Supports sequential advance with a configurable step, absolute jump, PC-relative branch, and call/return through an internal return-address stack (RAS).
- Sits in the fetch stage and drives the instruction memory address.
- Reports stack overflow and underflow through sticky flags for debug.

---
 rtl/program_counter_ras.sv | 177 +++++++++++++++++
 tb/tb_program_counter_ras.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/program_counter_ras.sv
// Fetch-stage program counter with seq/jump/branch/call/return and a circular return-address stack.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module program_counter_ras #(
    parameter int unsigned          DIR_SIZE     = 32,
    parameter int unsigned          STEP         = 4,
    parameter int unsigned          RAS_DEPTH    = 8,
    parameter logic [DIR_SIZE-1:0]  RESET_VECTOR = '0
`ifdef PC_MISALIGN_TRAP_EN
    ,
    parameter logic [DIR_SIZE-1:0]  TRAP_VECTOR  = 32'h80
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [2:0]                     mode,
    input  logic [DIR_SIZE-1:0]            dirIn,
    input  logic                           errClr,
    output logic [DIR_SIZE-1:0]            dirOut,
    output logic [$clog2(RAS_DEPTH):0]     rasCount,
    output logic                           rasOverflow,
`ifdef PC_MISALIGN_TRAP_EN
    output logic                           misaligned,
`endif
    output logic                           rasUnderflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] MODE_JUMP   = 3'b001;
    localparam logic [2:0] MODE_BRANCH = 3'b010;
    localparam logic [2:0] MODE_CALL   = 3'b011;
    localparam logic [2:0] MODE_RET    = 3'b100;

    logic [DIR_SIZE-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [DIR_SIZE-1:0] stack_q [RAS_DEPTH];

    logic [DIR_SIZE-1:0] seq_pc;
    logic [DIR_SIZE-1:0] target;
    logic [PTR_W-1:0]    top_idx;
    logic                is_call;
    logic                is_pop;
    logic                trap;
    logic                push_en;
    logic                ovf_set;
    logic                unf_set;
    logic                full;
    logic                empty;

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [DIR_SIZE-1:0] STEP_MASK = DIR_SIZE'(STEP - 1);
    logic is_ctrl;
    logic mis_q, mis_d;
`endif

    assign seq_pc  = pc_q + DIR_SIZE'(STEP);
    assign top_idx = ptr_q - PTR_W'(1);
    assign full    = (cnt_q == CNT_W'(RAS_DEPTH));
    assign empty   = (cnt_q == '0);

    // Decode the target address before any trap redirect is applied.
    always_comb begin
        target  = seq_pc;
        is_call = 1'b0;
        is_pop  = 1'b0;
        unf_set = 1'b0;
        if (enable) begin
            case (mode)
                MODE_JUMP:   target = dirIn;
                MODE_BRANCH: target = pc_q + dirIn;
                MODE_CALL: begin
                    target  = dirIn;
                    is_call = 1'b1;
                end
                MODE_RET: begin
                    if (!empty) begin
                        target = stack_q[top_idx];
                        is_pop = 1'b1;
                    end else begin
                        unf_set = 1'b1;
                    end
                end
                default: target = seq_pc;
            endcase
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign is_ctrl = enable && ((mode == MODE_JUMP) || (mode == MODE_BRANCH) ||
                                (mode == MODE_CALL) || (mode == MODE_RET && !empty));
    assign trap    = is_ctrl && ((target & STEP_MASK) != '0);
`else
    assign trap    = 1'b0;
`endif

    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        push_en = 1'b0;
        ovf_set = 1'b0;
        if (enable) begin
            pc_d = target;
`ifdef PC_MISALIGN_TRAP_EN
            if (trap) begin
                pc_d = TRAP_VECTOR;
            end
`endif
            // A trapped call leaves the stack untouched; a trapped return still pops.
            if (is_call && !trap) begin
                push_en = 1'b1;
                ptr_d   = ptr_q + PTR_W'(1);
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            if (is_pop) begin
                ptr_d = top_idx;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Set events take precedence over errClr.
    always_comb begin
        ovf_d = ovf_set ? 1'b1 : (errClr ? 1'b0 : ovf_q);
        unf_d = unf_set ? 1'b1 : (errClr ? 1'b0 : unf_q);
`ifdef PC_MISALIGN_TRAP_EN
        mis_d = trap ? 1'b1 : (errClr ? 1'b0 : mis_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VECTOR;
            cnt_q <= '0;
            ptr_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            mis_q <= 1'b0;
`endif
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
`ifdef PC_MISALIGN_TRAP_EN
            mis_q <= mis_d;
`endif
        end
    end

    // Stack contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[ptr_q] <= seq_pc;
        end
    end

    assign dirOut       = pc_q;
    assign rasCount     = cnt_q;
    assign rasOverflow  = ovf_q;
    assign rasUnderflow = unf_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign misaligned   = mis_q;
`endif

endmodule

// File: tb/tb_program_counter_ras.sv
// Directed self-checking bench for program_counter_ras (default parameters).
module tb_program_counter_ras;

    localparam logic [2:0] SEQ = 3'b000, JMP = 3'b001, BRA = 3'b010, CAL = 3'b011, RET = 3'b100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  mode = 3'b000;
    logic [31:0] dirIn = '0;
    logic        errClr = 1'b0;
    logic [31:0] dirOut;
    logic [3:0]  rasCount;
    logic        rasOverflow;
    logic        rasUnderflow;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    program_counter_ras dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .mode         (mode),
        .dirIn        (dirIn),
        .errClr       (errClr),
        .dirOut       (dirOut),
        .rasCount     (rasCount),
        .rasOverflow  (rasOverflow),
`ifdef PC_MISALIGN_TRAP_EN
        .misaligned   (misaligned),
`endif
        .rasUnderflow (rasUnderflow)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus and settle 1 time unit past the edge.
    task automatic cyc(input logic r, input logic en, input logic [2:0] m,
                       input logic [31:0] d, input logic clr);
        rst = r; enable = en; mode = m; dirIn = d; errClr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        cyc(1'b1, 1'b0, SEQ, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, CAL, 32'h1234, 1'b0);
        n_checks++; if (dirOut !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", dirOut, 32'h0); end
        n_checks++; if (rasCount !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", rasCount); end
        n_checks++; if (rasOverflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", rasOverflow); end
        n_checks++; if (rasUnderflow !== 1'b0) begin n_fail++; $display("FAIL reset_unf got %b want 0", rasUnderflow); end
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b0, 1'b1, SEQ, 32'h0, 1'b0);
            n_checks++; if (dirOut !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_%0d got %h want %h", i, dirOut, 32'(4 * i)); end
        end
        n_checks++; if ({rasOverflow, rasUnderflow} !== 2'b00) begin n_fail++; $display("FAIL seq_flags got %b want 00", {rasOverflow, rasUnderflow}); end
    endtask

    task automatic test_stall_jump;
        cyc(1'b0, 1'b1, JMP, 32'h8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, JMP, 32'h100, 1'b0);
            n_checks++; if (dirOut !== 32'h8) begin n_fail++; $display("FAIL stall_%0d got %h want 8", i, dirOut); end
        end
        cyc(1'b0, 1'b1, JMP, 32'h100, 1'b0);
        n_checks++; if (dirOut !== 32'h100) begin n_fail++; $display("FAIL jump got %h want 100", dirOut); end
    endtask

    task automatic test_branch;
        cyc(1'b0, 1'b1, BRA, 32'hFFFF_FFF0, 1'b0);
        n_checks++; if (dirOut !== 32'hF0) begin n_fail++; $display("FAIL branch_back got %h want f0", dirOut); end
        cyc(1'b0, 1'b1, BRA, 32'h20, 1'b0);
        n_checks++; if (dirOut !== 32'h110) begin n_fail++; $display("FAIL branch_fwd got %h want 110", dirOut); end
    endtask

    task automatic test_call_return;
        cyc(1'b0, 1'b1, JMP, 32'h40, 1'b0);
        cyc(1'b0, 1'b1, CAL, 32'h200, 1'b0);
        n_checks++; if (dirOut !== 32'h200 || rasCount !== 4'd1) begin n_fail++; $display("FAIL call1 got %h/%0d want 200/1", dirOut, rasCount); end
        cyc(1'b0, 1'b1, CAL, 32'h300, 1'b0);
        n_checks++; if (dirOut !== 32'h300 || rasCount !== 4'd2) begin n_fail++; $display("FAIL call2 got %h/%0d want 300/2", dirOut, rasCount); end
        // Stalled return must not pop.
        cyc(1'b0, 1'b0, RET, 32'h0, 1'b0);
        n_checks++; if (dirOut !== 32'h300 || rasCount !== 4'd2) begin n_fail++; $display("FAIL stall_ret got %h/%0d want 300/2", dirOut, rasCount); end
        cyc(1'b0, 1'b1, RET, 32'h0, 1'b0);
        n_checks++; if (dirOut !== 32'h204 || rasCount !== 4'd1) begin n_fail++; $display("FAIL ret1 got %h/%0d want 204/1", dirOut, rasCount); end
        cyc(1'b0, 1'b1, RET, 32'h0, 1'b0);
        n_checks++; if (dirOut !== 32'h44 || rasCount !== 4'd0) begin n_fail++; $display("FAIL ret2 got %h/%0d want 44/0", dirOut, rasCount); end
        cyc(1'b0, 1'b1, RET, 32'h0, 1'b0);
        n_checks++; if (dirOut !== 32'h48 || rasUnderflow !== 1'b1 || rasCount !== 4'd0) begin n_fail++; $display("FAIL underflow got %h/%b/%0d want 48/1/0", dirOut, rasUnderflow, rasCount); end
        // Undefined mode acts as seq and leaves the stack alone.
        cyc(1'b0, 1'b1, 3'b111, 32'h900, 1'b0);
        n_checks++; if (dirOut !== 32'h4C || rasCount !== 4'd0) begin n_fail++; $display("FAIL mode7 got %h/%0d want 4c/0", dirOut, rasCount); end
        // Set wins against a simultaneous clear.
        cyc(1'b0, 1'b1, RET, 32'h0, 1'b1);
        n_checks++; if (rasUnderflow !== 1'b1 || dirOut !== 32'h50) begin n_fail++; $display("FAIL set_wins got %b/%h want 1/50", rasUnderflow, dirOut); end
        // Clear works while stalled.
        cyc(1'b0, 1'b0, SEQ, 32'h0, 1'b1);
        n_checks++; if (rasUnderflow !== 1'b0 || dirOut !== 32'h50) begin n_fail++; $display("FAIL clr_stalled got %b/%h want 0/50", rasUnderflow, dirOut); end
    endtask

    task automatic test_overflow;
        logic [31:0] exp_pc;
        cyc(1'b0, 1'b1, JMP, 32'h1000, 1'b0);
        for (int k = 0; k < 9; k++) begin
            cyc(1'b0, 1'b0 | 1'b1, CAL, 32'h2000 + 32'(k) * 32'h100, 1'b0);
            if (k == 7) begin
                n_checks++; if (rasCount !== 4'd8 || rasOverflow !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf got %0d/%b want 8/0", rasCount, rasOverflow); end
            end
        end
        n_checks++; if (rasCount !== 4'd8 || rasOverflow !== 1'b1 || dirOut !== 32'h2800) begin n_fail++; $display("FAIL overflow got %0d/%b/%h want 8/1/2800", rasCount, rasOverflow, dirOut); end
        for (int k = 8; k >= 1; k--) begin
            cyc(1'b0, 1'b1, RET, 32'h0, 1'b0);
            exp_pc = 32'h2004 + 32'(k - 1) * 32'h100;
            n_checks++; if (dirOut !== exp_pc || rasCount !== 4'(k - 1)) begin n_fail++; $display("FAIL ovf_ret_%0d got %h/%0d want %h/%0d", k, dirOut, rasCount, exp_pc, k - 1); end
        end
        cyc(1'b0, 1'b1, SEQ, 32'h0, 1'b1);
        n_checks++; if (rasOverflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b want 0", rasOverflow); end
    endtask

    task automatic test_wrap_reset;
        cyc(1'b0, 1'b1, JMP, 32'hFFFF_FFFC, 1'b0);
        cyc(1'b0, 1'b1, SEQ, 32'h0, 1'b0);
        n_checks++; if (dirOut !== 32'h0) begin n_fail++; $display("FAIL wrap got %h want 0", dirOut); end
        cyc(1'b0, 1'b1, CAL, 32'h700, 1'b0);
        n_checks++; if (dirOut !== 32'h700 || rasCount !== 4'd1) begin n_fail++; $display("FAIL pre_rst_call got %h/%0d want 700/1", dirOut, rasCount); end
        cyc(1'b1, 1'b1, CAL, 32'h500, 1'b0);
        n_checks++; if (dirOut !== 32'h0 || rasCount !== 4'd0) begin n_fail++; $display("FAIL rst_call got %h/%0d want 0/0", dirOut, rasCount); end
    endtask

    task automatic test_back_to_back;
        cyc(1'b0, 1'b1, JMP, 32'h600, 1'b0);
        cyc(1'b0, 1'b1, CAL, 32'hA00, 1'b0);
        cyc(1'b0, 1'b1, RET, 32'h0, 1'b0);
        n_checks++; if (dirOut !== 32'h604 || rasCount !== 4'd0) begin n_fail++; $display("FAIL b2b_ret got %h/%0d want 604/0", dirOut, rasCount); end
        cyc(1'b0, 1'b1, BRA, 32'h0000_0010, 1'b0);
        n_checks++; if (dirOut !== 32'h614 || {rasOverflow, rasUnderflow} !== 2'b00) begin n_fail++; $display("FAIL b2b_branch got %h/%b want 614/00", dirOut, {rasOverflow, rasUnderflow}); end
    endtask

    initial begin
        test_reset();
        test_stall_jump();
        test_branch();
        test_call_return();
        test_overflow();
        test_wrap_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
